// File: rtl/rx_iq_pkg.sv
// rtl/rx_iq_pkg.sv - shared types, channel codes and the gain/round/saturate helper for rx_iq_pack
package rx_iq_pkg;

    typedef enum logic {
        WAIT_I = 1'b0,
        WAIT_Q = 1'b1
    } iq_state_t;

    localparam logic CH_I = 1'b0;
    localparam logic CH_Q = 1'b1;

    // Wide enough for IN_W+16 bits at the default IN_W, so shifting never wraps before saturation.
    localparam int ACC_W = 64;

    typedef struct packed {
        logic             sat;
        logic [ACC_W-1:0] val;
    } scale_res_t;

    function automatic scale_res_t scale_sat(
        input logic signed [ACC_W-1:0] x,
        input int                      sh,
        input int                      in_w,
        input int                      out_w
    );
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        scale_res_t              r;
        hi = (ACC_W'(1) << (out_w - 1)) - ACC_W'(1);
        lo = -(ACC_W'(1) << (out_w - 1));
        v = (x <<< sh) + (ACC_W'(1) << (in_w - out_w - 1));
        v = v >>> (in_w - out_w);
        r.sat = (v > hi) || (v < lo);
        r.val = (v > hi) ? hi : ((v < lo) ? lo : v);
        return r;
    endfunction

endpackage

// File: rtl/rx_iq_fifo.sv
// rtl/rx_iq_fifo.sv - synchronous first-word-fall-through FIFO for scaled I/Q pairs
module rx_iq_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop));

endmodule

// File: rtl/rx_iq_pack.sv
// rtl/rx_iq_pack.sv - re-pairs interleaved CIC I/Q beats, scales/saturates them and queues pairs; RX_IQ_PACK_IQSWAP_EN adds iq_swap
module rx_iq_pack
    import rx_iq_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 24,
    parameter int SH_W       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_channel,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic [1:0]        in_error,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SH_W-1:0]   gain_sh,
`ifdef RX_IQ_PACK_IQSWAP_EN
    input  logic              iq_swap,
`endif
    output logic [OUT_W-1:0]  out_i,
    output logic [OUT_W-1:0]  out_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf_flag,
    input  logic              ovf_clr,
    output logic [7:0]        sync_err_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    iq_state_t          state;
    logic [IN_W-1:0]    hold_i;
    logic               accept;
    logic               beat_bad;
    logic               pair_fire;
    logic               err_event;
    scale_res_t         res_i;
    scale_res_t         res_q;
    logic               s1_valid;
    logic [OUT_W-1:0]   s1_i;
    logic [OUT_W-1:0]   s1_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [2*OUT_W-1:0] fifo_rdata;

    assign accept    = in_valid && in_ready;
    assign beat_bad  = (in_error != 2'b00);
    assign pair_fire = accept && !beat_bad && (state == WAIT_Q) && (in_channel == CH_Q);
    assign err_event = accept && (beat_bad ||
                                  ((state == WAIT_I) && (in_channel == CH_Q)) ||
                                  ((state == WAIT_Q) && (in_channel == CH_I)));

    // Gain is taken from the Q beat's cycle, so mid-pair changes only affect the next pair.
    assign res_i = scale_sat(ACC_W'(signed'(hold_i)),  int'(gain_sh), IN_W, OUT_W);
    assign res_q = scale_sat(ACC_W'(signed'(in_data)), int'(gain_sh), IN_W, OUT_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_I;
            hold_i       <= '0;
            sync_err_cnt <= '0;
        end else begin
            if (err_event && (sync_err_cnt != 8'hFF)) sync_err_cnt <= sync_err_cnt + 8'd1;
            if (accept) begin
                if (beat_bad) begin
                    state <= WAIT_I;
                end else begin
                    case (state)
                        WAIT_I: begin
                            if (in_channel == CH_I) begin
                                hold_i <= in_data;
                                state  <= WAIT_Q;
                            end
                        end
                        WAIT_Q: begin
                            if (in_channel == CH_Q) state <= WAIT_I;
                            else hold_i <= in_data;
                        end
                        default: state <= WAIT_I;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            ovf_flag <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            s1_valid <= pair_fire;
            if (pair_fire) begin
`ifdef RX_IQ_PACK_IQSWAP_EN
                s1_i <= iq_swap ? res_q.val[OUT_W-1:0] : res_i.val[OUT_W-1:0];
                s1_q <= iq_swap ? res_i.val[OUT_W-1:0] : res_q.val[OUT_W-1:0];
`else
                s1_i <= res_i.val[OUT_W-1:0];
                s1_q <= res_q.val[OUT_W-1:0];
`endif
            end
            if (pair_fire && (res_i.sat || res_q.sat)) ovf_flag <= 1'b1;
            else if (ovf_clr)                          ovf_flag <= 1'b0;
            // Two slots of headroom cover the pair already in flight when ready is seen low.
            in_ready <= (int'(fifo_count) + int'(s1_valid)) <= (FIFO_DEPTH - 2);
        end
    end

    rx_iq_fifo #(
        .WIDTH (2*OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (s1_valid),
        .wdata   ({s1_i, s1_q}),
        .pop     (out_valid && out_ready),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_i     = fifo_rdata[2*OUT_W-1:OUT_W];
    assign out_q     = fifo_rdata[OUT_W-1:0];

    wire unused_ok = &{1'b0, in_startofpacket, in_endofpacket, fifo_full,
                       res_i.val[ACC_W-1:OUT_W], res_q.val[ACC_W-1:OUT_W]};

endmodule

// File: tb/tb_rx_iq_pack.sv
// tb/tb_rx_iq_pack.sv - directed self-checking bench for rx_iq_pack
module tb_rx_iq_pack;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_channel;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [1:0]  in_error;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  gain_sh;
    logic        iq_swap;
    logic [23:0] out_i;
    logic [23:0] out_q;
    logic        out_valid;
    logic        out_ready;
    logic        ovf_flag;
    logic        ovf_clr;
    logic [7:0]  sync_err_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_err  = 0;
    int          sent     = 0;
    logic [47:0] got[$];

    always #5 clk = ~clk;

    rx_iq_pack dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_error         (in_error),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .gain_sh          (gain_sh),
`ifdef RX_IQ_PACK_IQSWAP_EN
        .iq_swap          (iq_swap),
`endif
        .out_i            (out_i),
        .out_q            (out_q),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .ovf_flag         (ovf_flag),
        .ovf_clr          (ovf_clr),
        .sync_err_cnt     (sync_err_cnt)
    );

    // Record every handshake just before the edge that pops it.
    always @(negedge clk) begin
        #4;
        if (reset_n && out_valid && out_ready) got.push_back({out_i, out_q});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic ch, input logic [1:0] e);
        int n = 0;
        in_data          = d;
        in_channel       = ch;
        in_error         = e;
        in_startofpacket = ~ch;
        in_endofpacket   = ch;
        in_valid         = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_timeout", 64'(n < 200), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [47:0] got_at(input int idx);
        if (idx < got.size()) return got[idx];
        return 48'hDEAD_DEAD_DEAD;
    endfunction

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        logic [3:0]  sh;
        logic [23:0] ei;
        logic [23:0] eq;
        logic        eovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'h0001_0000, 32'hFFFF_0000, 4'd0,  24'h000100, 24'hFFFF00, 1'b0};
        vecs[1] = '{32'h4000_0000, 32'h0000_0000, 4'd2,  24'h7FFFFF, 24'h000000, 1'b1};
        vecs[2] = '{32'h0000_0080, 32'hFFFF_FF7F, 4'd0,  24'h000001, 24'hFFFFFF, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 4'd0,  24'h800000, 24'h7FFFFF, 1'b1};
        vecs[4] = '{32'h0000_0100, 32'hFFFF_FF00, 4'd15, 24'h008000, 24'hFF8000, 1'b0};
        vecs[5] = '{32'h0000_007F, 32'hFFFF_FF80, 4'd0,  24'h000000, 24'h000000, 1'b0};
        vecs[6] = '{32'h00FF_FF80, 32'h1234_5678, 4'd1,  24'h01FFFF, 24'h2468AD, 1'b0};

        reset_n = 1'b0; in_data = '0; in_channel = 1'b0; in_startofpacket = 1'b0;
        in_endofpacket = 1'b0; in_error = '0; in_valid = 1'b0; gain_sh = '0;
        iq_swap = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),     64'd0);
        check("rst_out_valid", 64'(out_valid),    64'd0);
        check("rst_out_i",     64'(out_i),        64'd0);
        check("rst_out_q",     64'(out_q),        64'd0);
        check("rst_ovf",       64'(ovf_flag),     64'd0);
        check("rst_err",       64'(sync_err_cnt), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // Single-pair scaling vectors: latency, value, overflow and clear.
        for (int k = 0; k < 7; k++) begin
            gain_sh = vecs[k].sh;
            send_beat(vecs[k].i, 1'b0, 2'b00);
            send_beat(vecs[k].q, 1'b1, 2'b00);
            check($sformatf("v%0d_valid_early", k), 64'(out_valid), 64'd0);
            check($sformatf("v%0d_ovf", k),         64'(ovf_flag),  64'(vecs[k].eovf));
            @(negedge clk);
            check($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_i", k),     64'(out_i),     64'(vecs[k].ei));
            check($sformatf("v%0d_q", k),     64'(out_q),     64'(vecs[k].eq));
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr = 1'b0;
            check($sformatf("v%0d_ovf_clr", k), 64'(ovf_flag), 64'd0);
        end
        gain_sh = '0;

        // Framing: Q,Q,I,I,Q yields one pair from the second I.
        got.delete();
        send_beat(32'h0000_0001, 1'b1, 2'b00);
        send_beat(32'h0000_0002, 1'b1, 2'b00);
        send_beat(32'h0001_0000, 1'b0, 2'b00);
        send_beat(32'h0002_0000, 1'b0, 2'b00);
        send_beat(32'h0003_0000, 1'b1, 2'b00);
        exp_err += 3;
        repeat (5) @(negedge clk);
        check("frm_pairs", 64'(got.size()),     64'd1);
        check("frm_pair",  64'(got_at(0)),      64'h000200_000300);
        check("frm_err",   64'(sync_err_cnt),   64'(exp_err));

        // Errored beat discards and returns to WAIT_I.
        got.delete();
        send_beat(32'h0005_0000, 1'b0, 2'b00);
        send_beat(32'h0006_0000, 1'b1, 2'b01);
        send_beat(32'h0006_0000, 1'b1, 2'b00);
        send_beat(32'h0007_0000, 1'b0, 2'b00);
        send_beat(32'h0008_0000, 1'b1, 2'b00);
        exp_err += 2;
        repeat (5) @(negedge clk);
        check("errb_pairs", 64'(got.size()),   64'd1);
        check("errb_pair",  64'(got_at(0)),    64'h000700_000800);
        check("errb_err",   64'(sync_err_cnt), 64'(exp_err));

        // Back-pressure: 20 pairs against a stalled consumer.
        got.delete();
        out_ready = 1'b0;
        sent = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    send_beat(32'((k + 1) << 8), 1'b0, 2'b00);
                    send_beat(32'(-((k + 1) << 8)), 1'b1, 2'b00);
                    sent++;
                end
            end
            begin
                int n = 0;
                while (in_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                repeat (10) @(negedge clk);
                check("bp_stall_ready", 64'(in_ready),  64'd0);
                check("bp_sent_range",  64'(sent >= 6 && sent <= 8), 64'd1);
                check("bp_no_pop",      64'(got.size()), 64'd0);
                check("bp_out_valid",   64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        join
        repeat (30) @(negedge clk);
        check("bp_count", 64'(got.size()), 64'd20);
        for (int k = 0; k < 20; k++)
            check($sformatf("bp_pair%0d", k), 64'(got_at(k)), 64'({24'(k + 1), 24'(-(k + 1))}));

        // Reset mid-pair with pairs queued and overflow set.
        out_ready = 1'b0;
        gain_sh = 4'd2;
        send_beat(32'h4000_0000, 1'b0, 2'b00);
        send_beat(32'h0000_0000, 1'b1, 2'b00);
        gain_sh = 4'd0;
        for (int k = 0; k < 2; k++) begin
            send_beat(32'h0000_1000, 1'b0, 2'b00);
            send_beat(32'h0000_2000, 1'b1, 2'b00);
        end
        send_beat(32'h0000_0011, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        check("mr_pre_valid", 64'(out_valid), 64'd1);
        check("mr_pre_ovf",   64'(ovf_flag),  64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mr_in_ready",  64'(in_ready),     64'd0);
        check("mr_out_valid", 64'(out_valid),    64'd0);
        check("mr_out_i",     64'(out_i),        64'd0);
        check("mr_out_q",     64'(out_q),        64'd0);
        check("mr_ovf",       64'(ovf_flag),     64'd0);
        check("mr_err",       64'(sync_err_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        got.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("mr_ready_after", 64'(in_ready), 64'd1);
        send_beat(32'h0009_0000, 1'b0, 2'b00);
        send_beat(32'h000A_0000, 1'b1, 2'b00);
        repeat (5) @(negedge clk);
        check("mr_pairs", 64'(got.size()),   64'd1);
        check("mr_pair",  64'(got_at(0)),    64'h000900_000A00);
        check("mr_err2",  64'(sync_err_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_iq_pack.md
Name: rx_iq_pack

Overview:
- Sits directly downstream of the RX CIC decimator.
- Consumes the CIC's interleaved Avalon-ST output stream: 32-bit samples, 1-bit channel, 0 = I, 1 = Q.
- Re-pairs the stream into parallel I/Q words, then applies programmable gain, rounding and saturation to OUT_W bits.
- Buffers the pairs in a small FWFT FIFO and presents them with a valid/ready handshake to the demodulator/audio-DSP path.

Parameters:
- IN_W, 32, input sample width (signed two's complement)
- OUT_W, 24, output I/Q width
- SH_W, 4, width of the gain shift control
- FIFO_DEPTH, 8, pair FIFO entries; must be a power of 2, minimum 4

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  IN_W  CIC sample
- in_channel  in  1  0 = I, 1 = Q
- in_startofpacket  in  1  expected with I
- in_endofpacket  in  1  expected with Q
- in_error  in  2  nonzero = bad beat
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept
- gain_sh  in  SH_W  left shift 0..15, sampled per pair at Q accept
- out_i  out  OUT_W  I sample
- out_q  out  OUT_W  Q sample
- out_valid  out  1  pair available
- out_ready  in  1  consumer accept
- ovf_flag  out  1  sticky saturation indicator
- ovf_clr  in  1  clears ovf_flag
- sync_err_cnt  out  8  saturating count of framing errors

Behaviour:
- Reset: in_ready=0 during reset, 1 the first cycle after; out_i=0, out_q=0, out_valid=0, ovf_flag=0, sync_err_cnt=0; FSM=WAIT_I; FIFO empty.
- A beat is accepted when in_valid and in_ready are both 1.
- FSM state WAIT_I:
  - Accepted channel 0: latch I into hold register, go to WAIT_Q.
  - Accepted channel 1: drop the beat, sync_err_cnt++, stay in WAIT_I.
- FSM state WAIT_Q:
  - Accepted channel 1: form pair (held I, this Q), push to scaler, go to WAIT_I.
  - Accepted channel 0: overwrite held I, sync_err_cnt++, stay in WAIT_Q.
- in_error!=0 on an accepted beat: beat discarded, FSM forced to WAIT_I, sync_err_cnt++.
- sop/eop are informational only; mismatches are not counted.
- sync_err_cnt saturates at 255; it is cleared only by reset.
- Scaling, per component:
  - v = sign-extend(x) << gain_sh
  - add 2^(IN_W-OUT_W-1) for round-half-up
  - arithmetic shift right by IN_W-OUT_W
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
  - Intermediate width is IN_W+16 bits, so nothing overflows before the saturation step.
- ovf_flag is set the cycle after any component saturates. ovf_clr clears it; set has priority over a simultaneous clr.
- Pipeline: pair formed in cycle n; scaled pair registered n+1; written to FIFO n+2. With the FIFO empty, out_valid rises at n+2 (FWFT).
- Back-pressure:
  - in_ready = (fifo_count + pipeline_occupancy) <= FIFO_DEPTH-2, registered.
  - A pair is never lost. A push into a full FIFO is a design error, covered by an assertion.
- FIFO:
  - Simultaneous push and pop when full or empty is legal; count is unchanged for full, and the pair is passed through for empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Output: out_i/out_q are stable while out_valid=1 and out_ready=0. The FIFO pops on out_valid && out_ready.
- gain_sh changes mid-pair take effect on the next Q accept only.

Optional Feature:
- Macro: RX_IQ_PACK_IQSWAP_EN.
- When defined:
  - Adds input port iq_swap (1 bit), sampled at Q accept.
  - When iq_swap=1, the pair is written to the FIFO with I and Q exchanged; this gives spectral inversion for lower-sideband reception.
- When undefined: port absent, no swap logic, I/Q order fixed.

Decomposition:
- Package rx_iq_pkg holds:
  - FSM state enum (WAIT_I, WAIT_Q)
  - CH_I=0 / CH_Q=1 constants
  - round/saturate function parameterised on IN_W/OUT_W
- One sub-module, rx_iq_fifo: synchronous FWFT FIFO with parameters width and depth, reset_n, push/pop, full/empty/count.

Test Plan:
- Alternating ch0=0x00010000 / ch1=0xFFFF0000, gain_sh=0, out_ready=1 -> out_i=0x000100, out_q=0xFFFF00, out_valid 2 cycles after the Q accept.
- ch0=0x40000000, gain_sh=2 -> out_i=0x7FFFFF (saturated), ovf_flag=1. Then ovf_clr pulse -> flag 0.
- Stream Q,Q,I,I,Q -> exactly one pair (second I with that Q), sync_err_cnt=3.
- out_ready=0 for 20 pairs -> in_ready drops after FIFO_DEPTH-2 pairs. Then release -> all pairs out in order, none lost.
- Rounding: ch0=0x00000080, gain_sh=0 -> out_i=1; ch0=0xFFFFFF7F -> out_i=-1.
- reset_n asserted mid-pair (WAIT_Q) with FIFO half full -> all outputs zero, FIFO empty, next I/Q pair is accepted normally after release.
